// File: rtl/iso_scene_renderer_if.sv
// iso_scene_renderer_if: framebuffer write port, valid (we) / ready handshake.
interface iso_scene_renderer_if #(
  parameter int ADDR_W = 16,
  parameter int COLOR_W = 3
);
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [COLOR_W-1:0] data;
  logic ready;
  modport master(output we, addr, data, input ready);
  modport slave(input we, addr, data, output ready);
endinterface

// File: rtl/iso_scene_renderer.sv
// iso_scene_renderer: clears a framebuffer, then draws isometric blocks and a player rectangle.
// Optional RENDER_AUTO_EN adds a free-running redraw timer of AUTO_PERIOD idle cycles.
module iso_scene_renderer #(
  parameter int PX_WIDTH = 160,
  parameter int PX_HEIGHT = 120,
  parameter int NUM_BLOCKS = 3,
  parameter int COORD_W = 8,
  parameter int COLOR_W = 3,
  parameter int PL_HALF_W = 2,
  parameter logic [COLOR_W-1:0] PL_COLOR = 3'b111,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0,
`ifdef RENDER_AUTO_EN
  parameter int AUTO_PERIOD = 1_000_000,
`endif
  parameter int ADDR_W = 16
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  input logic [NUM_BLOCKS*(4*COORD_W+3*COLOR_W)-1:0] blk_desc,
  input logic [NUM_BLOCKS-1:0] blk_en,
  input logic [3*COORD_W-1:0] pl_desc,
  iso_scene_renderer_if.master fb,
  output logic busy,
  output logic done,
  output logic [15:0] frame_cnt
);
  localparam int BW = 4*COORD_W + 3*COLOR_W;
  localparam int SW = COORD_W + 3;
  localparam int BIW = NUM_BLOCKS > 1 ? $clog2(NUM_BLOCKS) : 1;
  localparam logic signed [SW-1:0] ONE = SW'(1);
  localparam logic signed [SW-1:0] TWO = SW'(2);
  localparam logic signed [SW-1:0] HW = SW'(PL_HALF_W);
  localparam logic signed [SW-1:0] W_S = SW'(PX_WIDTH);
  localparam logic signed [SW-1:0] H_S = SW'(PX_HEIGHT);

  typedef enum logic [2:0] {IDLE, LATCH, CLEAR, TOP, LEFT, RIGHT, PLAYER, FIN} state_t;
  state_t state, state_n;
  logic [BIW-1:0] bi, bi_n, nbi;
  logic signed [SW-1:0] x, y, x_n, y_n;
  logic [NUM_BLOCKS*BW-1:0] blk_q;
  logic [NUM_BLOCKS-1:0] en_q;
  logic [3*COORD_W-1:0] pl_q;
  logic signed [SW-1:0] cx [NUM_BLOCKS];
  logic signed [SW-1:0] cy [NUM_BLOCKS];
  logic signed [SW-1:0] r [NUM_BLOCKS];
  logic signed [SW-1:0] h [NUM_BLOCKS];
  logic [COLOR_W-1:0] c1 [NUM_BLOCKS];
  logic [COLOR_W-1:0] c2 [NUM_BLOCKS];
  logic [COLOR_W-1:0] c3 [NUM_BLOCKS];
  logic signed [SW-1:0] px, py, ph;
  logic signed [SW-1:0] ccx, ccy, cr, ch, el, er, adx, ady;
  logic [COLOR_W-1:0] col;
  logic draw, inb, cand, adv, step, go;
  int nk, nb;

  // Unsigned fields widen with headroom so every edge/face coordinate stays exact.
  function automatic logic signed [SW-1:0] sx(input logic [COORD_W-1:0] v);
    return signed'({3'b000, v});
  endfunction

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_unpack
    assign cx[i] = sx(blk_q[i*BW +: COORD_W]);
    assign cy[i] = sx(blk_q[i*BW + COORD_W +: COORD_W]);
    assign r[i] = sx(blk_q[i*BW + 2*COORD_W +: COORD_W]);
    assign h[i] = sx(blk_q[i*BW + 3*COORD_W +: COORD_W]);
    assign c1[i] = blk_q[i*BW + 4*COORD_W +: COLOR_W];
    assign c2[i] = blk_q[i*BW + 4*COORD_W + COLOR_W +: COLOR_W];
    assign c3[i] = blk_q[i*BW + 4*COORD_W + 2*COLOR_W +: COLOR_W];
  end
  assign px = sx(pl_q[0 +: COORD_W]);
  assign py = sx(pl_q[COORD_W +: COORD_W]);
  assign ph = sx(pl_q[2*COORD_W +: COORD_W]);

`ifdef RENDER_AUTO_EN
  logic [31:0] acnt;
  logic auto_go;
  assign auto_go = state == IDLE && acnt == 32'(AUTO_PERIOD - 1);
  assign go = start || auto_go;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acnt <= '0;
    else acnt <= (start || auto_go) ? '0 : state == IDLE ? acnt + 32'd1 : acnt;
`else
  assign go = start;
`endif

  // el/er: face edge row under column x for the left/right side faces.
  always_comb begin
    ccx = cx[bi];
    ccy = cy[bi];
    cr = r[bi];
    ch = h[bi];
    el = ccy + x - ccx + cr;
    er = ccy + ccx + cr - x;
    adx = x < ccx ? ccx - x : x - ccx;
    ady = y < ccy ? ccy - y : y - ccy;
    draw = state inside {CLEAR, TOP, LEFT, RIGHT, PLAYER};
    inb = !x[SW-1] && !y[SW-1] && x < W_S && y < H_S;
    cand = draw && inb && (state != TOP || adx + ady <= cr);
    col = state == CLEAR ? BG_COLOR : state == TOP ? c1[bi] : state == LEFT ? c2[bi] :
          state == RIGHT ? c3[bi] : PL_COLOR;
  end

  assign adv = !cand || fb.ready;
  assign fb.we = cand;
  assign fb.addr = cand ? ADDR_W'(int'(y) * PX_WIDTH + int'(x)) : '0;
  assign fb.data = cand ? col : '0;
  assign busy = state != IDLE && state != FIN;
  assign done = state == FIN;

  always_comb begin
    state_n = state;
    bi_n = bi;
    x_n = x;
    y_n = y;
    step = 1'b0;
    nk = state == CLEAR ? 0 : int'(bi) + 1;
    nb = NUM_BLOCKS;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) if (i >= nk && en_q[i]) nb = i;
    nbi = BIW'(nb);
    case (state)
      IDLE: state_n = go ? LATCH : IDLE;
      LATCH: begin
        state_n = CLEAR;
        x_n = '0;
        y_n = '0;
      end
      CLEAR: if (adv) begin
        x_n = x == W_S - ONE ? '0 : x + ONE;
        y_n = x == W_S - ONE ? y + ONE : y;
        step = x == W_S - ONE && y == H_S - ONE;
      end
      TOP: if (adv) begin
        x_n = x == ccx + cr ? ccx - cr : x + ONE;
        y_n = x == ccx + cr ? y + ONE : y;
        if (x == ccx + cr && y == ccy + cr) begin
          state_n = LEFT;
          x_n = ccx - cr;
          y_n = ccy + ONE;
          step = ch == '0;
        end
      end
      LEFT: if (adv) begin
        x_n = y == el + ch ? x + ONE : x;
        y_n = y == el + ch ? el + TWO : y + ONE;
        if (y == el + ch && x == ccx) begin
          state_n = RIGHT;
          x_n = ccx + ONE;
          y_n = ccy + cr;
          step = cr == '0;
        end
      end
      RIGHT: if (adv) begin
        x_n = y == er + ch ? x + ONE : x;
        y_n = y == er + ch ? er : y + ONE;
        step = y == er + ch && x == ccx + cr;
      end
      PLAYER: if (adv) begin
        x_n = y == py - ph + ONE ? x + ONE : x;
        y_n = y == py - ph + ONE ? py : y - ONE;
        if (y == py - ph + ONE && x == px + HW) state_n = FIN;
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Disabled blocks and empty player are skipped without spending a cycle.
    if (step) begin
      state_n = nb < NUM_BLOCKS ? TOP : ph == '0 ? FIN : PLAYER;
      bi_n = nb < NUM_BLOCKS ? nbi : bi;
      x_n = nb < NUM_BLOCKS ? cx[nbi] - r[nbi] : px - HW;
      y_n = nb < NUM_BLOCKS ? cy[nbi] - r[nbi] : py;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bi <= '0;
      x <= '0;
      y <= '0;
      blk_q <= '0;
      en_q <= '0;
      pl_q <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      bi <= bi_n;
      x <= x_n;
      y <= y_n;
      frame_cnt <= frame_cnt + {15'd0, state == FIN};
      if (state == LATCH) begin
        blk_q <= blk_desc;
        en_q <= blk_en;
        pl_q <= pl_desc;
      end
    end
endmodule

// File: tb/tb_iso_scene_renderer.sv
// tb_iso_scene_renderer: scene-level model of the expected write stream, checked on every accepted write.
module tb_iso_scene_renderer;
  localparam int W = 16, H = 12, NB = 2, CW = 8, KW = 3, AW = 16;
  localparam int BW = 4*CW + 3*KW;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [NB*BW-1:0] blk_desc;
  logic [NB-1:0] blk_en;
  logic [3*CW-1:0] pl_desc;
  logic busy, done;
  logic [15:0] frame_cnt;

  iso_scene_renderer_if #(.ADDR_W(AW), .COLOR_W(KW)) fb();

  iso_scene_renderer #(.PX_WIDTH(W), .PX_HEIGHT(H), .NUM_BLOCKS(NB), .COORD_W(CW), .COLOR_W(KW),
                       .PL_HALF_W(1), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .blk_desc(blk_desc), .blk_en(blk_en),
    .pl_desc(pl_desc), .fb(fb), .busy(busy), .done(done), .frame_cnt(frame_cnt));

  int tests = 0, fails = 0, nwr = 0;
  bit mon_en = 0, bp = 0;
  int exp_a[$], exp_d[$];
  int bcx[NB], bcy[NB], br[NB], bh[NB], bc1[NB], bc2[NB], bc3[NB];
  bit ben[NB];
  int ppx, ppy, pph;

  initial forever #5 clk = ~clk;

  initial begin
    fb.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 fb.ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  task automatic push(input int px, input int py, input int c);
    if (px >= 0 && px < W && py >= 0 && py < H) begin
      exp_a.push_back(py * W + px);
      exp_d.push_back(c);
    end
  endtask

  task automatic build_model();
    exp_a.delete();
    exp_d.delete();
    for (int yy = 0; yy < H; yy++) for (int xx = 0; xx < W; xx++) push(xx, yy, 0);
    for (int b = 0; b < NB; b++) if (ben[b]) begin
      for (int yy = bcy[b] - br[b]; yy <= bcy[b] + br[b]; yy++)
        for (int xx = bcx[b] - br[b]; xx <= bcx[b] + br[b]; xx++)
          if (iabs(xx - bcx[b]) + iabs(yy - bcy[b]) <= br[b]) push(xx, yy, bc1[b]);
      if (bh[b] > 0) begin
        for (int xx = bcx[b] - br[b]; xx <= bcx[b]; xx++)
          for (int k = 1; k <= bh[b]; k++) push(xx, bcy[b] + xx - bcx[b] + br[b] + k, bc2[b]);
        for (int xx = bcx[b] + 1; xx <= bcx[b] + br[b]; xx++)
          for (int k = 1; k <= bh[b]; k++) push(xx, bcy[b] + bcx[b] + br[b] - xx + k, bc3[b]);
      end
    end
    for (int xx = ppx - 1; xx <= ppx + 1; xx++)
      for (int yy = ppy; yy > ppy - pph; yy--) push(xx, yy, 7);
  endtask

  task automatic set_block(input int b, input bit en, input int x0, input int y0, input int rr,
                           input int hh, input int k1, input int k2, input int k3);
    ben[b] = en; bcx[b] = x0; bcy[b] = y0; br[b] = rr; bh[b] = hh;
    bc1[b] = k1; bc2[b] = k2; bc3[b] = k3;
  endtask

  task automatic pack();
    for (int b = 0; b < NB; b++) begin
      blk_desc[b*BW +: BW] = {KW'(bc3[b]), KW'(bc2[b]), KW'(bc1[b]), CW'(bh[b]), CW'(br[b]),
                              CW'(bcy[b]), CW'(bcx[b])};
      blk_en[b] = ben[b];
    end
    pl_desc = {CW'(pph), CW'(ppy), CW'(ppx)};
  endtask

  // Single compare process: every accepted write against the model, plus hold-under-stall.
  initial begin
    bit stall;
    logic [AW-1:0] s_addr;
    logic [KW-1:0] s_data;
    stall = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (stall) begin
          chk("hold_we", fb.we, 1);
          chk("hold_addr", fb.addr, s_addr);
          chk("hold_data", fb.data, s_data);
        end
        if (fb.we && fb.ready) begin
          if (exp_a.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_write: got addr %0d, expected no write", fb.addr);
          end else begin
            chk("wr_addr", fb.addr, exp_a.pop_front());
            chk("wr_data", fb.data, exp_d.pop_front());
            nwr++;
          end
        end
        stall = fb.we && !fb.ready;
        s_addr = fb.addr;
        s_data = fb.data;
      end else stall = 0;
    end
  end

  task automatic run_frame(input int fc);
    bit got;
    pack();
    nwr = 0;
    mon_en = 1;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    chk("busy_after_start", busy, 1);
    got = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge clk);
      got = done;
    end
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_end", busy, 0);
    chk("frame_cnt", frame_cnt, fc);
    chk("exp_left", exp_a.size(), 0);
    mon_en = 0;
  endtask

  task automatic block_scene();
    set_block(0, 1, 8, 4, 2, 3, 1, 2, 3);
    set_block(1, 0, 3, 3, 1, 1, 5, 6, 4);
    ppx = 0; ppy = 0; pph = 0;
  endtask

  initial begin
    rst_n = 0;
    start = 0;
    set_block(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_block(1, 0, 0, 0, 0, 0, 0, 0, 0);
    ppx = 0; ppy = 0; pph = 0;
    pack();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", fb.we, 0);
    chk("rst_addr", fb.addr, 0);
    chk("rst_data", fb.data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1;
    repeat (100) begin
      @(negedge clk);
      chk("idle", {fb.we, busy, done, frame_cnt}, 0);
    end

    build_model();
    chk("model_clear_len", exp_a.size(), 192);
    chk("model_clear_last", exp_a[191], 191);
    run_frame(1);
    chk("clear_writes", nwr, 192);

    block_scene();
    build_model();
    chk("model_blk_len", exp_a.size(), 220);
    chk("model_top_first", exp_a[192], 40);
    chk("model_top_col", exp_d[204], 1);
    chk("model_left_first", exp_a[205], 86);
    chk("model_left_col", exp_d[205], 2);
    chk("model_right_first", exp_a[214], 105);
    chk("model_right_col", exp_d[219], 3);
    run_frame(2);
    chk("blk_writes", nwr, 220);

    set_block(0, 0, 8, 4, 2, 3, 1, 2, 3);
    ppx = 0; ppy = 1; pph = 4;
    build_model();
    chk("model_pl_len", exp_a.size(), 196);
    chk("model_pl_0", exp_a[192], 16);
    chk("model_pl_1", exp_a[193], 0);
    chk("model_pl_2", exp_a[194], 17);
    chk("model_pl_3", exp_a[195], 1);
    chk("model_pl_col", exp_d[195], 7);
    run_frame(3);
    chk("pl_writes", nwr, 196);

    block_scene();
    build_model();
    bp = 1;
    run_frame(4);
    bp = 0;
    chk("bp_writes", nwr, 220);

    block_scene();
    build_model();
    pack();
    nwr = 0;
    mon_en = 1;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (48) @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (49) @(posedge clk);
    #1;
    chk("busy_before_abort", busy, 1);
    chk("we_before_abort", fb.we, 1);
    #1 mon_en = 0;
    rst_n = 0;
    #1;
    chk("abort_we", fb.we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_frame_cnt", frame_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      chk("post_abort_idle", {fb.we, busy}, 0);
    end
    build_model();
    run_frame(1);
    chk("after_abort_writes", nwr, 220);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
